midi_note_receiver: RTL and testbench



---
 rtl/midi_note_receiver.sv | 149 ++++++++++++++
 tb/tb_midi_note_receiver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/midi_note_receiver.sv
// MIDI serial receiver (8N1) with a running-status parser that emits one pulse per
// accepted note-on carrying key and velocity.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge
// S_START | half-bit wait, confirming the start bit
// S_DATA  | sampling 8 data bits at bit centres, LSB first
// S_STOP  | sampling the stop bit; a good byte goes to the parser
module midi_note_receiver #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 31250,
  parameter int CHANNEL_EN  = 1,
  parameter int CHANNEL     = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_din,
  output logic [6:0] midi_key,
  output logic [6:0] midi_vel,
  output logic       midi_dout_valid,
  output logic       framing_err
);

  localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYCLES / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;
  typedef enum logic [2:0] {RS_NONE, RS_NOTE_ON, RS_NOTE_OFF, RS_OTHER1, RS_OTHER2} run_status_t;

  rx_state_t   state;
  run_status_t rs, rs_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        idx, idx_nxt;
  logic [6:0]  key_lat, key_lat_nxt;
  logic        hit;
  logic        chan_ok;

  // Parser next-state from the completed byte; committed only on a good stop bit.
  always_comb begin
    rs_nxt      = rs;
    idx_nxt     = idx;
    key_lat_nxt = key_lat;
    hit         = 1'b0;
    chan_ok     = (CHANNEL_EN == 0) || (shreg[3:0] == 4'(CHANNEL));
    if (shreg[7:3] == 5'b11111) begin
      rs_nxt = rs;
    end else if (shreg[7:4] == 4'hF) begin
      rs_nxt  = RS_NONE;
      idx_nxt = 1'b0;
    end else if (shreg[7]) begin
      idx_nxt = 1'b0;
      case (shreg[7:4])
        4'h9:       rs_nxt = chan_ok ? RS_NOTE_ON : RS_OTHER2;
        4'h8:       rs_nxt = chan_ok ? RS_NOTE_OFF : RS_OTHER2;
        4'hC, 4'hD: rs_nxt = RS_OTHER1;
        default:    rs_nxt = RS_OTHER2;
      endcase
    end else begin
      case (rs)
        RS_NOTE_ON: begin
          if (!idx) begin
            key_lat_nxt = shreg[6:0];
            idx_nxt     = 1'b1;
          end else begin
            idx_nxt = 1'b0;
            hit     = (shreg[6:0] != 7'd0);
          end
        end
        RS_NOTE_OFF, RS_OTHER2: idx_nxt = ~idx;
        default:                idx_nxt = idx;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      rs              <= RS_NONE;
      cnt             <= '0;
      bit_idx         <= 3'd0;
      shreg           <= 8'd0;
      idx             <= 1'b0;
      key_lat         <= 7'd0;
      midi_key        <= 7'd0;
      midi_vel        <= 7'd0;
      midi_dout_valid <= 1'b0;
      framing_err     <= 1'b0;
    end else begin
      midi_dout_valid <= 1'b0;
      framing_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!midi_din) begin
            state <= S_START;
            cnt   <= HALF_M1;
          end
        end
        S_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!midi_din) begin
            state   <= S_DATA;
            cnt     <= FULL_M1;
            bit_idx <= 3'd0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shreg   <= {midi_din, shreg[7:1]};
            cnt     <= FULL_M1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= S_IDLE;
            if (midi_din) begin
              rs      <= rs_nxt;
              idx     <= idx_nxt;
              key_lat <= key_lat_nxt;
              if (hit) begin
                midi_key        <= key_lat;
                midi_vel        <= shreg[6:0];
                midi_dout_valid <= 1'b1;
              end
            end else begin
              framing_err <= 1'b1;
              rs          <= RS_NONE;
              idx         <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_note_receiver.sv
// Directed bench for midi_note_receiver: serialises MIDI bytes at a short bit period
// and checks note-on pulses, framing errors, reset behaviour and latency.
module tb_midi_note_receiver;

  localparam int CLK_HZ = 500_000;
  localparam int BAUD   = 31250;
  localparam int B      = CLK_HZ / BAUD;   // 16 clocks per bit
  localparam int H      = B / 2;
  localparam int LAT    = H + 2 + 9 * B;   // start-bit drive to first negedge showing the pulse

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       midi_din = 1'b1;
  logic [6:0] midi_key, midi_vel;
  logic       midi_dout_valid, framing_err;

  midi_note_receiver #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .CHANNEL_EN(1), .CHANNEL(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .midi_din(midi_din),
    .midi_key(midi_key), .midi_vel(midi_vel),
    .midi_dout_valid(midi_dout_valid), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, start_cyc = 0, last_lat = 0;
  int n_fe = 0, hold_err = 0;
  logic [6:0] pk[$], pv[$];
  logic [6:0] prev_key = 7'd0, prev_vel = 7'd0;

  always @(negedge clk) begin
    cyc++;
    if (midi_dout_valid) begin
      pk.push_back(midi_key);
      pv.push_back(midi_vel);
      last_lat = cyc - start_cyc;
    end
    if (framing_err) n_fe++;
    if (rst_n && !midi_dout_valid && (midi_key != prev_key || midi_vel != prev_vel)) hold_err++;
    prev_key = midi_key;
    prev_vel = midi_vel;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Caller is at posedge+1; each frame bit is held for B clocks.
  task automatic send_bits(input logic [9:0] frame, input int nb);
    for (int i = 0; i < nb; i++) begin
      midi_din = frame[i];
      if (i == 0) start_cyc = cyc;
      repeat (B) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    send_bits({stop_bit, b, 1'b0}, 10);
    midi_din = 1'b1;
    repeat (2 * B) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    pk.delete();
    pv.delete();
  endtask

  task automatic check_one(input string tag, input int key, input int vel);
    check_val({tag, "_n"}, pk.size(), 1);
    if (pk.size() >= 1) begin
      check_val({tag, "_key"}, pk[0], key);
      check_val({tag, "_vel"}, pv[0], vel);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_key", midi_key, 0);
    check_val("rst_vel", midi_vel, 0);
    check_val("rst_valid", midi_dout_valid, 0);
    rst_n = 1'b1;
    repeat (2 * B) @(posedge clk);
    #1;

    // Basic note-on and latency
    clear_q();
    send_byte(8'h99); send_byte(8'h24); send_byte(8'h64);
    check_one("basic", 36, 100);
    check_val("basic_lat", last_lat, LAT);
    check_val("basic_fe", n_fe, 0);

    // Running status
    clear_q();
    send_byte(8'h99); send_byte(8'h26); send_byte(8'h40); send_byte(8'h2A); send_byte(8'h7F);
    check_val("rs_n", pk.size(), 2);
    if (pk.size() == 2) begin
      check_val("rs_key0", pk[0], 38); check_val("rs_vel0", pv[0], 64);
      check_val("rs_key1", pk[1], 42); check_val("rs_vel1", pv[1], 127);
    end

    // Velocity 0 and note-off give nothing
    clear_q();
    send_byte(8'h99); send_byte(8'h24); send_byte(8'h00);
    send_byte(8'h89); send_byte(8'h24); send_byte(8'h40);
    check_val("vel0_noteoff_n", pk.size(), 0);
    send_byte(8'h99); send_byte(8'h30); send_byte(8'h10);
    check_one("after_off", 48, 16);

    // Real-time byte between key and velocity
    clear_q();
    send_byte(8'h99); send_byte(8'h2D); send_byte(8'hF8); send_byte(8'h50);
    check_one("realtime", 45, 80);

    // Framing error on key byte
    clear_q();
    send_byte(8'h99); send_byte(8'h24, 1'b0); send_byte(8'h64);
    check_val("fe_count", n_fe, 1);
    check_val("fe_n", pk.size(), 0);
    send_byte(8'h99); send_byte(8'h24); send_byte(8'h64);
    check_one("after_fe", 36, 100);

    // Wrong channel
    clear_q();
    send_byte(8'h90); send_byte(8'h24); send_byte(8'h64);
    check_val("chan_n", pk.size(), 0);

    // Reset part-way through the velocity byte
    clear_q();
    send_byte(8'h99); send_byte(8'h24);
    send_bits({1'b1, 8'h64, 1'b0}, 5);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst_key", midi_key, 0);
    check_val("midrst_vel", midi_vel, 0);
    check_val("midrst_valid", midi_dout_valid, 0);
    @(posedge clk);
    #1;
    midi_din = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * B) @(posedge clk);
    #1;
    check_val("midrst_n", pk.size(), 0);
    // Running status is NONE after reset: bare data bytes are ignored
    send_byte(8'h24); send_byte(8'h64);
    check_val("postrst_data_n", pk.size(), 0);
    send_byte(8'h99); send_byte(8'h24); send_byte(8'h64);
    check_one("postrst", 36, 100);

    check_val("fe_total", n_fe, 1);
    check_val("hold", hold_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
